arm_multicycle_ctrl: RTL and testbench

Multicycle control unit for the ARMv4 subset: ADD, SUB, AND, ORR, CMP, LDR, STR, B, all with conditional execution. It replaces the single-cycle controller when the datapath shares one memory and one ALU across cycles through IR, Data, A/WriteData and ALUOut registers. It sequences each instruction through a Moore FSM and owns the NZCV flag register and the condition check.

---
 rtl/arm_multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARMv4-subset controller: a Moore FSM sequencing each instruction over
// the shared memory/ALU datapath, plus the NZCV flag register and condition check.
module arm_multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [19:0]        instr_i,
  input  logic [3:0]         alu_flags_i,
  output logic               pc_write_o,
  output logic               adr_src_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic [1:0]         result_src_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         imm_src_o,
  output logic               reg_write_o,
  output logic [1:0]         reg_src_o,
  output logic [1:0]         alu_control_o,
  output logic [3:0]         flags_o,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
    StMemWr, StExecR, StExecI, StAluWb, StBranch
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ok_q, cond_ok_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit, s_bit, rd_pc;
  logic [3:0] cmd;
  logic       cmd_ok, is_cmp, is_arith;
  logic [1:0] dp_alu;
  logic       pc_we, ir_we, mem_we, reg_we;
  logic       unused_instr;

  assign cond  = instr_i[19:16];
  assign op    = instr_i[15:14];
  assign i_bit = instr_i[13];
  assign cmd   = instr_i[12:9];
  assign s_bit = instr_i[8];  // S for data processing, L for memory
  assign rd_pc = (instr_i[3:0] == 4'hF);
  assign unused_instr = ^instr_i[7:4];

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_check = z;
      4'h1:    cond_check = ~z;
      4'h2:    cond_check = cf;
      4'h3:    cond_check = ~cf;
      4'h4:    cond_check = n;
      4'h5:    cond_check = ~n;
      4'h6:    cond_check = v;
      4'h7:    cond_check = ~v;
      4'h8:    cond_check = cf & ~z;
      4'h9:    cond_check = ~cf | z;
      4'hA:    cond_check = (n == v);
      4'hB:    cond_check = (n != v);
      4'hC:    cond_check = ~z & (n == v);
      4'hD:    cond_check = z | (n != v);
      4'hE:    cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  always_comb begin
    cmd_ok   = 1'b1;
    is_cmp   = 1'b0;
    is_arith = 1'b1;
    dp_alu   = 2'b00;
    case (cmd)
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b0000: begin dp_alu = 2'b10; is_arith = 1'b0; end
      4'b1100: begin dp_alu = 2'b11; is_arith = 1'b0; end
      4'b1010: begin dp_alu = 2'b01; is_cmp = 1'b1; end
      default: begin cmd_ok = 1'b0; is_arith = 1'b0; end
    endcase
  end

  always_comb begin
    state_d       = StFetch;
    flags_d       = flags_q;
    cond_ok_d     = cond_ok_q;
    pc_we         = 1'b0;
    ir_we         = 1'b0;
    mem_we        = 1'b0;
    reg_we        = 1'b0;
    adr_src_o     = 1'b0;
    result_src_o  = 2'b00;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    imm_src_o     = 2'b00;
    reg_src_o     = 2'b00;
    alu_control_o = 2'b00;
    unique case (state_q)
      StFetch: begin
        ir_we        = 1'b1;
        pc_we        = 1'b1;
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        state_d      = StDecode;
      end
      StDecode: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        reg_src_o    = {(op == 2'b01) & ~s_bit, op == 2'b10};
        imm_src_o    = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        cond_ok_d    = cond_check(cond, flags_q);
        case (op)
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          2'b00:   state_d = !cmd_ok ? StFetch : (i_bit ? StExecI : StExecR);
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        alu_src_b_o = 2'b01;
        imm_src_o   = 2'b01;
        state_d     = s_bit ? StMemRd : StMemWr;
      end
      StMemRd: begin
        adr_src_o = 1'b1;
        state_d   = StMemWb;
      end
      StMemWb: begin
        result_src_o = 2'b01;
        reg_we       = cond_ok_q;
        pc_we        = cond_ok_q & rd_pc;
      end
      StMemWr: begin
        adr_src_o = 1'b1;
        mem_we    = cond_ok_q;
      end
      StExecR, StExecI: begin
        alu_src_b_o   = (state_q == StExecI) ? 2'b01 : 2'b00;
        alu_control_o = dp_alu;
        // cond_ok_q was frozen in DECODE, so this write cannot affect our own writeback
        if (cond_ok_q && (s_bit || is_cmp)) begin
          flags_d[3:2] = alu_flags_i[3:2];
          if (is_arith) flags_d[1:0] = alu_flags_i[1:0];
        end
        state_d = is_cmp ? StFetch : StAluWb;
      end
      StAluWb: begin
        reg_we = cond_ok_q;
        pc_we  = cond_ok_q & rd_pc;
      end
      StBranch: begin
        reg_src_o    = 2'b01;
        alu_src_b_o  = 2'b01;
        imm_src_o    = 2'b10;
        result_src_o = 2'b10;
        pc_we        = cond_ok_q;
      end
      default: state_d = StFetch;
    endcase
  end

  // Enables are masked during reset since FETCH would otherwise assert them
  assign pc_write_o  = pc_we & ~reset_i;
  assign ir_write_o  = ir_we & ~reset_i;
  assign mem_write_o = mem_we & ~reset_i;
  assign reg_write_o = reg_we & ~reset_i;
  assign flags_o     = flags_q;
  assign state_o     = state_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StFetch;
      flags_q   <= 4'b0000;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: directed and random instructions checked cycle by
// cycle against an instruction-level reference model of the controller.
module tb_arm_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [19:0] instr_i;
  logic [3:0]  alu_flags_i;
  logic        pc_write_o, adr_src_o, mem_write_o, ir_write_o, alu_src_a_o, reg_write_o;
  logic [1:0]  result_src_o, alu_src_b_o, imm_src_o, reg_src_o, alu_control_o;
  logic [3:0]  flags_o;
  logic [3:0]  state_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  model_flags;

  arm_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .instr_i(instr_i), .alu_flags_i(alu_flags_i),
    .pc_write_o(pc_write_o), .adr_src_o(adr_src_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .result_src_o(result_src_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .imm_src_o(imm_src_o), .reg_write_o(reg_write_o),
    .reg_src_o(reg_src_o), .alu_control_o(alu_control_o), .flags_o(flags_o),
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ARM condition field: odd codes are the negation of the even code below them
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    {n, z, cc, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af_fixed, input bit rand_af);
    int          st[$];
    logic [1:0]  op;
    logic [3:0]  cmd;
    bit          cok, valid_dp, is_cmp, arith, l_s, rd15;
    logic [3:0]  af;
    logic [3:0]  exp_en;
    logic [11:0] exp_mux;
    logic [1:0]  aluc;
    op    = ins[15:14];
    cmd   = ins[12:9];
    l_s   = ins[8];
    rd15  = (ins[3:0] == 4'hF);
    valid_dp = cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    is_cmp   = (cmd == 4'b1010);
    arith    = cmd inside {4'b0100, 4'b0010, 4'b1010};
    aluc     = (cmd == 4'b0000) ? 2'd2 : (cmd == 4'b1100) ? 2'd3 :
               (cmd == 4'b0100) ? 2'd0 : 2'd1;
    instr_i  = ins;
    cok      = cond_holds(ins[19:16], model_flags);
    st = '{0, 1};
    if (op == 2'b01) begin
      st.push_back(2);
      if (l_s) begin st.push_back(3); st.push_back(4); end
      else st.push_back(5);
    end else if (op == 2'b10) begin
      st.push_back(9);
    end else if (op == 2'b00 && valid_dp) begin
      st.push_back(ins[13] ? 7 : 6);
      if (!is_cmp) st.push_back(8);
    end
    foreach (st[k]) begin
      int s;
      s = st[k];
      exp_en = {(s == 0) || (s == 9 && cok) || ((s == 4 || s == 8) && cok && rd15),
                s == 0, s == 5 && cok, (s == 4 || s == 8) && cok};
      exp_mux[11]    = (s == 3 || s == 5);                                  // adr_src
      exp_mux[10:9]  = (s <= 1 || s == 9) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0; // result_src
      exp_mux[8]     = (s <= 1);                                           // alu_src_a
      exp_mux[7:6]   = (s <= 1) ? 2'd2 : (s == 2 || s == 7 || s == 9) ? 2'd1 : 2'd0;
      exp_mux[5:4]   = (s == 2) ? 2'd1 : (s == 9) ? 2'd2 :
                       (s == 1) ? ((op == 2'b01) ? 2'd1 : (op == 2'b10) ? 2'd2 : 2'd0) : 2'd0;
      exp_mux[3:2]   = (s == 9) ? 2'b01 :
                       (s == 1) ? {op == 2'b01 && !l_s, op == 2'b10} : 2'b00;
      exp_mux[1:0]   = (s == 6 || s == 7) ? aluc : 2'd0;
      check_eq("state", 16'(state_o), 16'(s));
      check_eq("flags", 16'(flags_o), 16'(model_flags));
      check_eq("enables{pc,ir,mem,reg}",
               16'({pc_write_o, ir_write_o, mem_write_o, reg_write_o}), 16'(exp_en));
      check_eq("mux_selects",
               16'({adr_src_o, result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o,
                    reg_src_o, alu_control_o}), 16'(exp_mux));
      af = rand_af ? 4'($urandom) : af_fixed;
      alu_flags_i = af;
      @(posedge clk_i);
      #1;
      if ((s == 6 || s == 7) && cok && (l_s || is_cmp)) begin
        model_flags[3:2] = af[3:2];
        if (arith) model_flags[1:0] = af[1:0];
      end
    end
  endtask

  function automatic logic [19:0] rand_instr();
    logic [19:0] w;
    logic [3:0]  cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    w = 20'($urandom);
    if ($urandom_range(0, 2) != 0) w[19:16] = 4'hE;
    w[15:14] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    if ($urandom_range(0, 4) != 0) w[12:9] = cmds[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) w[3:0] = 4'hF;
    return w;
  endfunction

  initial begin
    reset_i     = 1'b1;
    instr_i     = '0;
    alu_flags_i = '0;
    model_flags = '0;
    #1;
    check_eq("reset_state", 16'(state_o), 16'd0);
    check_eq("reset_flags", 16'(flags_o), 16'd0);
    check_eq("reset_enables",
             16'({pc_write_o, ir_write_o, mem_write_o, reg_write_o}), 16'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;

    run_instr(20'hE2802, 4'hF, 1'b0);  // ADD R2,R0,#5: no S, flags untouched
    run_instr(20'hE0513, 4'b0110, 1'b0);  // SUBS R3,R1,R1
    run_instr(20'h02802, 4'h0, 1'b0);  // ADDEQ executes
    run_instr(20'h12802, 4'h0, 1'b0);  // ADDNE suppressed
    run_instr(20'hE3510, 4'b1000, 1'b0);  // CMP R1,#7
    run_instr(20'hE5902, 4'h0, 1'b0);  // LDR
    run_instr(20'hE5802, 4'h0, 1'b0);  // STR
    run_instr(20'h0A000, 4'h0, 1'b0);  // BEQ not taken (Z=0)
    run_instr(20'hE3510, 4'b0100, 1'b0);
    run_instr(20'h0A000, 4'h0, 1'b0);  // BEQ taken
    run_instr(20'hE590F, 4'h0, 1'b0);  // LDR into PC
    run_instr(20'hF2802, 4'h0, 1'b0);  // cond=1111 never executes

    for (int i = 0; i < 200; i++) run_instr(rand_instr(), 4'h0, 1'b1);

    // Abort an LDR in MEMRD with an asynchronous reset
    run_instr(20'hE3510, 4'hF, 1'b0);
    instr_i = 20'hE5902;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    check_eq("pre_reset_state", 16'(state_o), 16'd3);
    #2 reset_i = 1'b1;
    #1;
    check_eq("async_reset_state", 16'(state_o), 16'd0);
    check_eq("async_reset_flags", 16'(flags_o), 16'd0);
    check_eq("async_reset_enables",
             16'({pc_write_o, ir_write_o, mem_write_o, reg_write_o}), 16'd0);
    @(posedge clk_i);
    #1;
    check_eq("held_reset_state", 16'(state_o), 16'd0);
    check_eq("held_reset_enables",
             16'({pc_write_o, ir_write_o, mem_write_o, reg_write_o}), 16'd0);
    reset_i = 1'b0;
    model_flags = '0;
    #1;
    for (int i = 0; i < 30; i++) run_instr(rand_instr(), 4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
